buzzer_scheduler: RTL
=====================

# buzzer_scheduler

Shares one alarm path between N_CH debounced sensor channels. Each channel qualifies its sensor input with a stability counter and latches a sticky request. A round-robin scheduler then plays the requests one at a time: a fixed-length one-hot buzzer burst, followed by a silent guard gap. The block sits between the raw ui_in sensor pins and the uo_out buzzer pins, and replaces ad-hoc "last sensor wins" logic with fair, lossless servicing.

## Interface
Parameters:
- N_CH, 3: number of sensor/buzzer channels (2..8).
- DEBOUNCE, 7: consecutive high samples required to qualify a sensor (1..15).
- ON_CYCLES, 31: cycles the granted buzzer is held high (1..255).
- GAP_CYCLES, 8: silent cycles after each burst (0..255; 0 means return straight to IDLE).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- ena  in  1  clock enable; when low, all state and outputs hold.
- sensor  in  N_CH  raw sensor levels, already synchronised upstream.
- mask  in  N_CH  1 = channel disabled.
- buzz  out  N_CH  one-hot buzzer drive, or all zero.
- busy  out  1  high in ON or GAP.
- pending  out  N_CH  latched, not-yet-served requests.
- grant_id  out  clog2(N_CH)  index of the last granted channel.

## Operation
- Reset values: buzz = 0, busy = 0, pending = 0, grant_id = N_CH-1, state = IDLE, all counters = 0. Reset has priority over ena.
- Debounce, per channel:
  - sensor high and not masked: count increments, saturating at DEBOUNCE.
  - sensor low, or channel masked: count clears to 0.
  - pending[i] sets on the edge where the count goes from DEBOUNCE-1 to DEBOUNCE. This gives one event per assertion; a held sensor does not re-trigger until it has gone low.
- Masked channels never set pending. Asserting mask[i] clears pending[i] on the next edge.
- Eligible set = pending & ~mask.
- FSM states:
  - IDLE: if eligible is non-zero, pick the first eligible channel searching from grant_id+1 (mod N_CH) upward. On that edge, move to ON, set buzz to the one-hot of the pick, set grant_id to the pick, clear pending of the pick, and load the on counter. If eligible is zero, stay in IDLE.
  - ON: buzz is held. After ON_CYCLES cycles, clear buzz and go to GAP, or to IDLE if GAP_CYCLES = 0.
  - GAP: buzz = 0. After GAP_CYCLES cycles, go to IDLE.
- Requests arriving during ON or GAP stay latched and are served in round-robin order.
- If the same channel gets a new set on the same edge that clears its pending for a grant, the set wins: pending stays 1.
- A mask applied to the granted channel during ON does not cut the burst short.
- Arithmetic: counters are unsigned. Debounce counters are 4 bits; ON and GAP counters are 8 bits. No wrap is allowed: the parameter ranges above are enforced by elaboration-time checks.

## Timing
- Debounce latency: sensor high from edge k gives pending high after edge k+DEBOUNCE-1.
- Grant latency: the edge after pending is visible, buzz rises.
- With the defaults, a sensor rising before edge 0 gives pending after edge 6 and buzz high during cycles 8..38. That is exactly ON_CYCLES = 31 cycles, followed by 8 gap cycles.
- Back-to-back grant period: ON_CYCLES + GAP_CYCLES + 1 cycles, where the +1 is the IDLE decision cycle.
- busy is registered with the state: high from the first buzz cycle to the last gap cycle.
- ena low freezes all counters, the FSM, pending and outputs exactly. Sensor samples are ignored while ena is low.
- A reset mid-burst forces buzz = 0 and pending = 0 on that edge. Requests lost to the reset are not replayed.

## Structure
- Package buzz_pkg holds:
  - the FSM state enum (IDLE, ON, GAP);
  - the counter width constants DB_W = 4 and TMR_W = 8;
  - a function onehot(idx) and a function rr_pick(eligible, last).
- Sub-module sensor_debounce: per-channel saturating counter plus pending-set pulse output, instantiated N_CH times.
- The scheduler FSM, round-robin pick and timers live in the top level.

## Test plan
- Single request: sensor[0] held for 10 cycles, defaults. Required: pending[0] after edge 6; buzz = 001 for 31 cycles; busy high for 39 cycles; grant_id = 0.
- Bounce rejection: sensor[1] high 6 cycles, low 1 cycle, high 6 cycles. Required: pending stays 0 and buzz stays 0 throughout.
- Fairness: all three sensors qualify on the same edge. Required: bursts in order ch0, ch1, ch2; each buzz rise is 40 cycles after the previous one; pending drains 111 → 110 → 100 → 000.
- Mask: mask = 010 while pending = 110 and ch2 is in ON. Required: pending becomes 100 on the next edge and ch1 is never granted; the ch2 burst still lasts a full 31 cycles.
- Freeze and reset: ena low for 5 cycles mid-burst. Required: the burst length extends by exactly 5 cycles. Then rst_n low during ON. Required: buzz, busy and pending are 0 after that edge, and grant_id = 2.
- GAP_CYCLES = 0 with two requests pending. Required: the second buzz rises 32 cycles after the first.

Source files
------------

// File: rtl/buzz_pkg.sv
// Shared types, widths and helpers for the buzzer scheduler slice.
package buzz_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ON,
        GAP
    } state_t;

    localparam int unsigned DB_W   = 4;
    localparam int unsigned TMR_W  = 8;
    localparam int unsigned MAX_CH = 8;
    localparam int unsigned IDX_W  = 3;

    function automatic logic [MAX_CH-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [MAX_CH-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Scans downward so the last hit is the nearest channel after 'last'.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [MAX_CH-1:0] eligible,
                                                 input logic [IDX_W-1:0]  last,
                                                 input int unsigned       n);
        logic [IDX_W-1:0] pick;
        int unsigned      t;
        pick = last;
        for (int unsigned k = n; k >= 1; k--) begin
            t = 32'(last) + k;
            if (t >= n) t = t - n;
            if (eligible[t[IDX_W-1:0]]) pick = t[IDX_W-1:0];
        end
        return pick;
    endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Per-channel saturating stability counter; pulses set_pulse once per qualified assertion.
module sensor_debounce
    import buzz_pkg::*;
#(
    parameter int unsigned DEBOUNCE = 7
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic sensor,
    input  logic mask,
    output logic set_pulse
);

    logic [DB_W-1:0] cnt;
    logic            qual;

    assign qual      = sensor & ~mask;
    assign set_pulse = ena & qual & (cnt == DB_W'(DEBOUNCE - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (ena) begin
            if (!qual) begin
                cnt <= '0;
            end else if (cnt != DB_W'(DEBOUNCE)) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/buzzer_scheduler.sv
// Debounced multi-channel alarm requests served round-robin as one-hot bursts plus a guard gap.
module buzzer_scheduler
    import buzz_pkg::*;
#(
    parameter int unsigned N_CH       = 3,
    parameter int unsigned DEBOUNCE   = 7,
    parameter int unsigned ON_CYCLES  = 31,
    parameter int unsigned GAP_CYCLES = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ena,
    input  logic [N_CH-1:0]         sensor,
    input  logic [N_CH-1:0]         mask,
    output logic [N_CH-1:0]         buzz,
    output logic                    busy,
    output logic [N_CH-1:0]         pending,
    output logic [$clog2(N_CH)-1:0] grant_id
);

    localparam int unsigned GW = $clog2(N_CH);

    if (N_CH < 2 || N_CH > MAX_CH) begin : g_bad_n_ch
        $error("N_CH must be in 2..8");
    end
    if (DEBOUNCE < 1 || DEBOUNCE > 15) begin : g_bad_debounce
        $error("DEBOUNCE must be in 1..15");
    end
    if (ON_CYCLES < 1 || ON_CYCLES > 255) begin : g_bad_on
        $error("ON_CYCLES must be in 1..255");
    end
    if (GAP_CYCLES > 255) begin : g_bad_gap
        $error("GAP_CYCLES must be in 0..255");
    end

    logic [N_CH-1:0] set_vec;

    for (genvar i = 0; i < N_CH; i++) begin : g_db
        sensor_debounce #(
            .DEBOUNCE(DEBOUNCE)
        ) u_db (
            .clk      (clk),
            .rst_n    (rst_n),
            .ena      (ena),
            .sensor   (sensor[i]),
            .mask     (mask[i]),
            .set_pulse(set_vec[i])
        );
    end

    state_t           state, state_next;
    logic [TMR_W-1:0] tmr, tmr_next;
    logic [N_CH-1:0]  buzz_next, pending_next, eligible, grant_oh;
    logic             busy_next;
    logic [GW-1:0]    gid_next;
    logic [IDX_W-1:0] pick;

    always_comb begin
        eligible   = pending & ~mask;
        pick       = rr_pick(MAX_CH'(eligible), IDX_W'(grant_id), N_CH);
        state_next = state;
        tmr_next   = tmr;
        buzz_next  = buzz;
        gid_next   = grant_id;
        grant_oh   = '0;

        case (state)
            IDLE: begin
                if (eligible != '0) begin
                    state_next = ON;
                    tmr_next   = TMR_W'(ON_CYCLES - 1);
                    grant_oh   = N_CH'(onehot(pick));
                    buzz_next  = grant_oh;
                    gid_next   = GW'(pick);
                end
            end
            ON: begin
                if (tmr == '0) begin
                    buzz_next = '0;
                    if (GAP_CYCLES == 0) begin
                        state_next = IDLE;
                    end else begin
                        state_next = GAP;
                        tmr_next   = TMR_W'(GAP_CYCLES - 1);
                    end
                end else begin
                    tmr_next = tmr - 1'b1;
                end
            end
            GAP: begin
                if (tmr == '0) begin
                    state_next = IDLE;
                end else begin
                    tmr_next = tmr - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        busy_next = (state_next != IDLE);
        // A fresh set on the grant edge survives the grant clear.
        pending_next = (pending & ~mask & ~grant_oh) | set_vec;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            tmr      <= '0;
            buzz     <= '0;
            busy     <= 1'b0;
            pending  <= '0;
            grant_id <= GW'(N_CH - 1);
        end else if (ena) begin
            state    <= state_next;
            tmr      <= tmr_next;
            buzz     <= buzz_next;
            busy     <= busy_next;
            pending  <= pending_next;
            grant_id <= gid_next;
        end
    end

endmodule
